// File: rtl/fp4_e2m1_pkg.sv
// Shared types and helpers for the FP4 E2M1 dot-product datapath.
// Magnitudes are kept in half units so every product is an exact integer in quarter units.
package fp4_e2m1_pkg;

  localparam int PROD_W = 9;

  typedef struct packed {
    logic       sign;
    logic [1:0] exp;
    logic       man;
  } e2m1_t;

  // Indexed by {exp, man}; entry 0 is the lowest nibble of the vector.
  localparam logic [7:0][3:0] E2M1_MAG_HALF = {
    4'd12, 4'd8, 4'd6, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0
  };

  function automatic logic [3:0] e2m1_mag_half(input e2m1_t v);
    return E2M1_MAG_HALF[{v.exp, v.man}];
  endfunction

endpackage

// File: rtl/fp4_e2m1_lane_mul.sv
// Exact signed product of one E2M1 operand pair, in quarter units.
// Zero-magnitude products are forced to +0 so -0 never leaks a sign.
module fp4_e2m1_lane_mul
  import fp4_e2m1_pkg::*;
(
  input  logic        [3:0]        a,
  input  logic        [3:0]        b,
  output logic signed [PROD_W-1:0] prod
);

  e2m1_t                 op_a;
  e2m1_t                 op_b;
  logic [7:0]            mag;
  logic [PROD_W-1:0]     mag_ext;
  logic                  neg;

  always_comb begin
    op_a    = e2m1_t'(a);
    op_b    = e2m1_t'(b);
    mag     = {4'b0, e2m1_mag_half(op_a)} * {4'b0, e2m1_mag_half(op_b)};
    mag_ext = {1'b0, mag};
    neg     = (op_a.sign ^ op_b.sign) && (mag != 8'd0);
    prod    = neg ? -$signed(mag_ext) : $signed(mag_ext);
  end

endmodule

// File: rtl/fp4_e2m1_dot_accum.sv
// N-lane FP4 E2M1 dot product with streaming accumulator: multiply, reduce, accumulate.
// One global advance enable stalls all three stages while a result waits downstream.
module fp4_e2m1_dot_accum
  import fp4_e2m1_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int ACC_W    = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4*LANES-1:0]   in_a_i,
  input  logic [4*LANES-1:0]   in_b_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_W-1:0]     out_data_o,
  output logic                 out_ovf_o
);

  localparam int SUM_W = PROD_W + $clog2(LANES);
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  logic adv;

  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic                     s1_valid_q;
  logic                     s1_last_q;

  logic signed [SUM_W-1:0]  tree_sum;
  logic signed [SUM_W-1:0]  sum_q;
  logic                     s2_valid_q;
  logic                     s2_last_q;

  logic [ACC_W-1:0]         acc_q;
  logic                     ovf_q;
  logic signed [ACC_W:0]    full_sum;
  logic [ACC_W-1:0]         acc_next;
  logic                     acc_ovf;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp4_e2m1_lane_mul u_mul (
      .a    (in_a_i[4*g +: 4]),
      .b    (in_b_i[4*g +: 4]),
      .prod (prod_d[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid_i;
      s1_last_q  <= in_last_i;
      prod_q     <= prod_d;
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) tree_sum = tree_sum + SUM_W'(prod_q[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      sum_q      <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      sum_q      <= tree_sum;
    end
  end

  // One guard bit holds the exact sum so overflow is judged before clamp or wrap.
  always_comb begin
    full_sum = $signed({acc_q[ACC_W-1], acc_q}) + (ACC_W+1)'(sum_q);
    acc_next = full_sum[ACC_W-1:0];
    acc_ovf  = 1'b0;
    if (SATURATE) begin
      if (full_sum > ACC_MAX) begin
        acc_next = ACC_MAX[ACC_W-1:0];
        acc_ovf  = 1'b1;
      end else if (full_sum < ACC_MIN) begin
        acc_next = ACC_MIN[ACC_W-1:0];
        acc_ovf  = 1'b1;
      end
    end else begin
      acc_ovf = full_sum[ACC_W] ^ full_sum[ACC_W-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ovf_o   <= 1'b0;
    end else if (adv) begin
      out_valid_o <= 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          out_data_o  <= acc_next;
          out_ovf_o   <= ovf_q | acc_ovf;
          out_valid_o <= 1'b1;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
        end else begin
          acc_q <= acc_next;
          ovf_q <= ovf_q | acc_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp4_e2m1_dot_accum.sv
// Self-checking bench: three 4-lane instances (24b saturating, 12b saturating, 12b wrapping)
// share one stimulus stream; an arithmetic reference model feeds per-instance scoreboards.
module tb_fp4_e2m1_dot_accum;

  localparam int L = 4;

  typedef struct {
    longint d;
    bit     o;
  } res_t;

  typedef struct {
    logic [4*L-1:0] a;
    logic [4*L-1:0] b;
    longint         exp_d;
    bit             exp_o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, out_ready;
  logic [4*L-1:0] in_a, in_b;
  logic rdy0, rdy1, rdy2, ov0, ov1, ov2, of0, of1, of2;
  logic [23:0] d0;
  logic [11:0] d1, d2;

  always #5 clk = ~clk;

  fp4_e2m1_dot_accum #(.LANES(L), .ACC_W(24), .SATURATE(1'b1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last), .out_valid_o(ov0),
    .out_ready_i(out_ready), .out_data_o(d0), .out_ovf_o(of0));

  fp4_e2m1_dot_accum #(.LANES(L), .ACC_W(12), .SATURATE(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last), .out_valid_o(ov1),
    .out_ready_i(out_ready), .out_data_o(d1), .out_ovf_o(of1));

  fp4_e2m1_dot_accum #(.LANES(L), .ACC_W(12), .SATURATE(1'b0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy2),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last), .out_valid_o(ov2),
    .out_ready_i(out_ready), .out_data_o(d2), .out_ovf_o(of2));

  int tests = 0;
  int fails = 0;
  int out_cnt0 = 0;

  int     half_val [8] = '{0, 1, 2, 3, 4, 6, 8, 12};
  int     acc_w    [3] = '{24, 12, 12};
  bit     sat      [3] = '{1'b1, 1'b1, 1'b0};
  longint m_acc    [3];
  bit     m_ovf    [3];
  res_t   exp_q    [3][$];

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Beat value in quarter units straight from the E2M1 value table.
  function automatic longint beat_sum(input logic [4*L-1:0] a, input logic [4*L-1:0] b);
    longint s;
    longint p;
    logic [3:0] x;
    logic [3:0] y;
    s = 0;
    for (int k = 0; k < L; k++) begin
      x = a[4*k +: 4];
      y = b[4*k +: 4];
      p = longint'(half_val[x[2:0]] * half_val[y[2:0]]);
      if (x[3] ^ y[3]) p = -p;
      s += p;
    end
    return s;
  endfunction

  function automatic void apply(input int w, input bit s, input longint full,
                                output longint r, output bit o);
    longint mx;
    longint md;
    mx = (longint'(1) << (w - 1)) - 1;
    md = longint'(1) << w;
    o  = (full > mx) || (full < -mx - 1) || (s && full == -mx - 1);
    if (s) begin
      r = (full > mx) ? mx : (full < -mx) ? -mx : full;
    end else begin
      r = ((full % md) + md) % md;
      if (r > mx) r -= md;
    end
  endfunction

  task automatic model_accept(input logic [4*L-1:0] a, input logic [4*L-1:0] b, input logic last);
    longint s;
    longint r;
    bit o;
    s = beat_sum(a, b);
    for (int i = 0; i < 3; i++) begin
      apply(acc_w[i], sat[i], m_acc[i] + s, r, o);
      if (last) begin
        exp_q[i].push_back('{r, m_ovf[i] | o});
        m_acc[i] = 0;
        m_ovf[i] = 1'b0;
      end else begin
        m_acc[i] = r;
        m_ovf[i] = m_ovf[i] | o;
      end
    end
  endtask

  task automatic chk_out(input int i, input longint got, input bit go);
    res_t e;
    if (exp_q[i].size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb%0d unexpected result: got %0d expected none", i, got);
    end else begin
      e = exp_q[i].pop_front();
      check($sformatf("sb%0d data", i), got, e.d);
      check($sformatf("sb%0d ovf", i), longint'(go), longint'(e.o));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (ov0) begin
        chk_out(0, longint'($signed(d0)), of0);
        out_cnt0++;
      end
      if (ov1) chk_out(1, longint'($signed(d1)), of1);
      if (ov2) chk_out(2, longint'($signed(d2)), of2);
    end
  end

  // Entered and left at posedge+1; each call offers one beat until accepted.
  task automatic send_beat(input logic [4*L-1:0] a, input logic [4*L-1:0] b, input logic last);
    bit ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = rdy0 && rdy1 && rdy2;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send timeout: got no accept expected accept");
    end else begin
      model_accept(a, b, last);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_result(output longint r0, output longint r1, output longint r2,
                             output bit o0, output bit o1, output bit o2, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov0 && lat < 20);
    r0 = longint'($signed(d0));
    r1 = longint'($signed(d1));
    r2 = longint'($signed(d2));
    o0 = of0;
    o1 = of1;
    o2 = of2;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst out_valid", longint'(ov0), 0);
    check("rst in_ready", longint'(rdy0), 1);
    check("rst out_data", longint'(d0), 0);
    check("rst out_ovf", longint'(of0), 0);
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
      exp_q[i].delete();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t   tbl [4];
    longint r0, r1, r2;
    bit     o0, o1, o2;
    int     lat, cnt_before;
    bit     done;
    logic [4*L-1:0] ra, rb;
    int     len;

    tbl[0] = '{16'h2222, 16'h7777, 96, 1'b0};
    tbl[1] = '{16'h1118, 16'h9997, -3, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h7777, -576, 1'b0};
    tbl[3] = '{16'h0A53, 16'h3C61, 59, 1'b0};

    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 4; i++) begin
      send_beat(tbl[i].a, tbl[i].b, 1'b1);
      wait_result(r0, r1, r2, o0, o1, o2, lat);
      check($sformatf("vec%0d latency", i), lat, 3);
      check($sformatf("vec%0d data", i), r0, tbl[i].exp_d);
      check($sformatf("vec%0d ovf", i), longint'(o0), longint'(tbl[i].exp_o));
    end

    cnt_before = out_cnt0;
    send_beat(16'h7777, 16'h7777, 1'b0);
    send_beat(16'h7777, 16'h7777, 1'b0);
    send_beat(16'h7777, 16'h7777, 1'b1);
    wait_result(r0, r1, r2, o0, o1, o2, lat);
    check("three-beat data", r0, 1728);
    idle(6);
    check("three-beat output count", out_cnt0 - cnt_before, 1);

    send_beat(16'h7777, 16'h7777, 1'b0);
    send_beat(16'h7777, 16'h7777, 1'b0);
    send_beat(16'h7777, 16'h7777, 1'b0);
    send_beat(16'h7777, 16'h7777, 1'b1);
    wait_result(r0, r1, r2, o0, o1, o2, lat);
    check("max w24 data", r0, 2304);
    check("max w24 ovf", longint'(o0), 0);
    check("max sat12 data", r1, 2047);
    check("max sat12 ovf", longint'(o1), 1);
    check("max wrap12 data", r2, -1792);
    check("max wrap12 ovf", longint'(o2), 1);
    send_beat(16'h0001, 16'h0001, 1'b1);
    wait_result(r0, r1, r2, o0, o1, o2, lat);
    check("after sat12 data", r1, 1);
    check("after sat12 ovf", longint'(o1), 0);
    check("after wrap12 data", r2, 1);
    check("after wrap12 ovf", longint'(o2), 0);

    out_ready = 1'b0;
    fork
      begin
        send_beat(16'h2222, 16'h2222, 1'b1);
        send_beat(16'h1111, 16'h7777, 1'b0);
        send_beat(16'h3333, 16'h5555, 1'b1);
        send_beat(16'h7777, 16'hCCCC, 1'b1);
      end
      begin
        longint held;
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!ov0 && n < 20);
        check("stall result appears", longint'(ov0), 1);
        held = longint'(d0);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall in_ready", longint'(rdy0), 0);
          check("stall out_valid", longint'(ov0), 1);
          check("stall data", longint'(d0), held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(10);
    check("stall sb0 drained", exp_q[0].size(), 0);

    send_beat(16'h7777, 16'h7777, 1'b0);
    send_beat(16'h7777, 16'h7777, 1'b0);
    do_reset();
    send_beat(16'h2222, 16'h2222, 1'b1);
    wait_result(r0, r1, r2, o0, o1, o2, lat);
    check("post-reset data", r0, 16);
    check("post-reset ovf", longint'(o0), 0);

    done = 1'b0;
    fork
      begin
        for (int v = 0; v < 40; v++) begin
          len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rb = 16'h7777;
            send_beat(ra, rb, k == len - 1);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(10);
    for (int i = 0; i < 3; i++) check($sformatf("random sb%0d drained", i), exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
